// File: rtl/joyserializer_neptuno.sv
// Joystick shift-register emulator: parallel-loads two 8-bit joystick words and shifts them out
// MSB first under control of an external (asynchronous) joy_clk / active-low joy_load pair.
module joyserializer_neptuno #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        FILL        = 1'b1,
  parameter int unsigned NBITS       = 16
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       joy_clk_i,
  input  logic       joy_load_i,
  input  logic [7:0] joy1_i,
  input  logic [7:0] joy2_i,
  output logic       joy_data_o,
  output logic [4:0] bit_cnt_o,
  output logic       frame_o
);

  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] ld_sync_q;
  logic                   clk_s_d_q;
  logic                   ld_s_d_q;
  logic                   clk_s;
  logic                   ld_s;
  logic                   clk_rise;
  logic                   shift_en;

  logic [NBITS-1:0]       shreg_q, shreg_d;
  logic [4:0]             cnt_q, cnt_d;
  logic                   frame_q, frame_d;
  logic                   data_q;

  // Synchronise joy_clk (idle low) and joy_load (idle high) into the clk_i domain.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      clk_sync_q <= '0;
      ld_sync_q  <= '1;
      clk_s_d_q  <= 1'b0;
      ld_s_d_q   <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], joy_clk_i};
      ld_sync_q  <= {ld_sync_q[SYNC_STAGES-2:0], joy_load_i};
      clk_s_d_q  <= clk_s;
      ld_s_d_q   <= ld_s;
    end
  end

  assign clk_s    = clk_sync_q[SYNC_STAGES-1];
  assign ld_s     = ld_sync_q[SYNC_STAGES-1];
  assign clk_rise = clk_s & ~clk_s_d_q;
  // Load must have been high for two cycles, so a clk rise coinciding with release is not a shift.
  assign shift_en = clk_rise & ld_s & ld_s_d_q;

  // Next state: load dominates, otherwise shift in FILL on a qualified joy_clk rise.
  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    frame_d = 1'b0;
    if (!ld_s) begin
      shreg_d = {joy1_i, joy2_i};
      cnt_d   = '0;
    end else if (shift_en) begin
      shreg_d = {shreg_q[NBITS-2:0], FILL};
      if (cnt_q != 5'd31) begin
        cnt_d = cnt_q + 5'd1;
      end
      frame_d = (cnt_q == 5'(NBITS - 1));
    end
  end

  // State and registered serial output.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      shreg_q <= {NBITS{FILL}};
      cnt_q   <= '0;
      frame_q <= 1'b0;
      data_q  <= FILL;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
      data_q  <= shreg_q[NBITS-1];
    end
  end

  assign joy_data_o = data_q;
  assign bit_cnt_o  = cnt_q;
  assign frame_o    = frame_q;

endmodule

// File: tb/tb_joyserializer_neptuno.sv
// Scoreboard bench: the stimulus pushes the expected serial bit before every joy_clk rise, and a
// monitor pops and compares joy_data_o at each rise the decoder would sample.
module tb_joyserializer_neptuno;

  logic       clk_i = 1'b0;
  logic       rst_n_i = 1'b0;
  logic       joy_clk_i = 1'b0;
  logic       joy_load_i = 1'b1;
  logic [7:0] joy1_i = 8'h00;
  logic [7:0] joy2_i = 8'h00;
  logic       joy_data_o;
  logic [4:0] bit_cnt_o;
  logic       frame_o;

  int checks = 0;
  int errors = 0;
  int frame_cnt = 0;
  logic exp_q[$];

  joyserializer_neptuno dut (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .joy_clk_i  (joy_clk_i),
    .joy_load_i (joy_load_i),
    .joy1_i     (joy1_i),
    .joy2_i     (joy2_i),
    .joy_data_o (joy_data_o),
    .bit_cnt_o  (bit_cnt_o),
    .frame_o    (frame_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: decoder samples data at each joy_clk rise while load is high.
  always @(posedge joy_clk_i) begin
    if (rst_n_i && joy_load_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL serial_unexpected: got %0d expected none", joy_data_o);
      end else begin
        logic e;
        e = exp_q.pop_front();
        chk("serial_bit", int'(joy_data_o), int'(e));
      end
    end
  end

  // Count frame pulses away from the active edge.
  always @(negedge clk_i) begin
    if (frame_o) frame_cnt++;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  // One joy_clk period with an expected sampled bit at the rise.
  task automatic joy_pulse(input logic exp_bit);
    exp_q.push_back(exp_bit);
    wait_clk(8);
    joy_clk_i = 1'b1;
    wait_clk(8);
    joy_clk_i = 1'b0;
  endtask

  task automatic do_load(input logic [7:0] j1, input logic [7:0] j2);
    joy1_i     = j1;
    joy2_i     = j2;
    joy_load_i = 1'b0;
    wait_clk(16);
    joy_load_i = 1'b1;
    wait_clk(8);
  endtask

  task automatic send_bits(input logic [15:0] pat, input int n);
    for (int i = 0; i < n; i++) joy_pulse(pat[15-i]);
  endtask

  initial begin
    // T1: reset with toggling inputs.
    for (int i = 0; i < 12; i++) begin
      wait_clk(1);
      joy_clk_i  = ~joy_clk_i;
      joy_load_i = i[1];
      joy1_i     = 8'(i * 37);
      joy2_i     = 8'(i * 11);
      if (i % 4 == 3) begin
        chk("reset_data", int'(joy_data_o), 1);
        chk("reset_cnt", int'(bit_cnt_o), 0);
        chk("reset_frame", int'(frame_o), 0);
      end
    end
    joy_clk_i  = 1'b0;
    joy_load_i = 1'b1;
    wait_clk(2);
    rst_n_i = 1'b1;
    wait_clk(20);
    chk("post_reset_data", int'(joy_data_o), 1);
    chk("post_reset_cnt", int'(bit_cnt_o), 0);
    chk("post_reset_frames", frame_cnt, 0);

    // T2: full frame A5 / 3C.
    do_load(8'hA5, 8'h3C);
    chk("load_cnt", int'(bit_cnt_o), 0);
    send_bits(16'hA53C, 16);
    chk("frame_cnt_16", int'(bit_cnt_o), 16);
    chk("frame_pulses_t2", frame_cnt, 1);

    // T3: overrun shifts FILL, no further pulse.
    send_bits(16'hFFFF, 3);
    chk("overrun_cnt", int'(bit_cnt_o), 19);
    chk("frame_pulses_t3", frame_cnt, 1);

    // T4: load dominance, joy_clk ignored, data tracks joy1[7].
    joy1_i = 8'h80;
    joy2_i = 8'h00;
    joy_load_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wait_clk(4);
      joy_clk_i = ~joy_clk_i;
    end
    wait_clk(4);
    chk("dom_cnt", int'(bit_cnt_o), 0);
    chk("dom_data_hi", int'(joy_data_o), 1);
    joy1_i = 8'h00;
    wait_clk(4);
    chk("dom_data_lo", int'(joy_data_o), 0);
    chk("dom_cnt2", int'(bit_cnt_o), 0);
    joy1_i = 8'h81;
    wait_clk(4);
    chk("dom_data_hi2", int'(joy_data_o), 1);
    joy_load_i = 1'b1;
    wait_clk(3);
    joy1_i = 8'h00;  // must be ignored after release
    wait_clk(5);
    send_bits(16'h8100, 8);
    chk("dom_cnt_8", int'(bit_cnt_o), 8);

    // T5: abort at bit 7 then reset at bit 9.
    do_load(8'hF0, 8'h0F);
    send_bits(16'hF00F, 7);
    do_load(8'h5A, 8'hC3);
    chk("abort_cnt", int'(bit_cnt_o), 0);
    send_bits(16'h5AC3, 9);
    chk("abort_cnt_9", int'(bit_cnt_o), 9);
    chk("abort_frames", frame_cnt, 1);
    rst_n_i = 1'b0;
    wait_clk(1);
    chk("midreset_data", int'(joy_data_o), 1);
    chk("midreset_cnt", int'(bit_cnt_o), 0);
    wait_clk(3);
    rst_n_i = 1'b1;
    wait_clk(10);
    chk("after_reset_data", int'(joy_data_o), 1);
    chk("after_reset_cnt", int'(bit_cnt_o), 0);
    do_load(8'h69, 8'h96);
    send_bits(16'h6996, 16);
    chk("fresh_cnt", int'(bit_cnt_o), 16);
    chk("fresh_frames", frame_cnt, 2);

    wait_clk(10);
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
